// File: rtl/gf_mul_192.sv
// gf_mul_192: iterative 192x192-bit unsigned multiplier for P-192 GF(p) work.
// A single 64x64 multiplier is time-shared over the limb pairs and the
// 384-bit product is accumulated in place. The product is presented together
// with a one-cycle finish pulse.
// Optional build macro GF_MUL_SQR_EN: when a==b at capture, a 6-product
// squaring schedule is used, with the off-diagonal terms doubled.
`ifndef BW_GF
`define BW_GF 192
`endif

module gf_mul_192 #(
  parameter int LIMB_W = 64,
  parameter int a_len  = `BW_GF,
  parameter int p_len  = 2 * `BW_GF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [a_len-1:0] a,
  input  logic [a_len-1:0] b,
  output logic             busy,
  output logic [p_len-1:0] p,
  output logic             finish
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t              state, state_nx;
  logic [3:0]          k;
  logic [a_len-1:0]    ra, rb;
  logic [p_len-1:0]    acc;
  logic [1:0]          li, lj;
  logic                dbl;
  logic                last;
  logic [LIMB_W-1:0]   limb_a, limb_b;
  logic [2*LIMB_W-1:0] prod;
  logic [p_len-1:0]    term;
  int                  sh;
`ifdef GF_MUL_SQR_EN
  logic                sqr;
`endif

  // Limb-pair schedule: which limbs feed the multiplier at step k
  always_comb begin
    li   = 2'(k / 4'd3);
    lj   = 2'(k % 4'd3);
    dbl  = 1'b0;
    last = (k == 4'd8);
`ifdef GF_MUL_SQR_EN
    // Squaring visits only the upper triangle; each off-diagonal pair stands
    // for both (i,j) and (j,i), so it is added once with one extra left shift.
    if (sqr) begin
      last = (k == 4'd5);
      case (k)
        4'd0:    begin li = 2'd0; lj = 2'd0; end
        4'd1:    begin li = 2'd0; lj = 2'd1; end
        4'd2:    begin li = 2'd0; lj = 2'd2; end
        4'd3:    begin li = 2'd1; lj = 2'd1; end
        4'd4:    begin li = 2'd1; lj = 2'd2; end
        default: begin li = 2'd2; lj = 2'd2; end
      endcase
      dbl = (li != lj);
    end
`endif
  end

  // Shared limb multiplier and placement of its product within the accumulator
  always_comb begin
    limb_a = ra[LIMB_W*li +: LIMB_W];
    limb_b = rb[LIMB_W*lj +: LIMB_W];
    prod   = (2*LIMB_W)'(limb_a) * (2*LIMB_W)'(limb_b);
    sh     = LIMB_W * (int'(li) + int'(lj)) + (dbl ? 1 : 0);
    term   = p_len'(prod) << sh;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and busy flag
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (valid) state_nx = MUL;
      MUL:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, accumulation and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      ra     <= '0;
      rb     <= '0;
      acc    <= '0;
      p      <= '0;
      finish <= 1'b0;
`ifdef GF_MUL_SQR_EN
      sqr    <= 1'b0;
`endif
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            ra  <= a;
            rb  <= b;
            acc <= '0;
            k   <= '0;
`ifdef GF_MUL_SQR_EN
            sqr <= (a == b);
`endif
          end
        end
        MUL: begin
          acc <= acc + term;
          k   <= k + 4'd1;
        end
        DONE: begin
          p      <= acc;
          finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gf_mul_192.md
Name: gf_mul_192

Overview:
Iterative 192x192-bit unsigned multiplier for P-192 GF(p) arithmetic in the ECDH datapath. It sits directly upstream of the 192-bit modular reduction stage: its 384-bit product and finish pulse connect straight to that stage's a/valid inputs. It uses one 64x64 multiplier, time-shared over limb pairs, to keep area low.

Parameters:
a_len, `BW_GF (192), operand width; must equal 3*LIMB_W.
p_len, 2*`BW_GF (384), product width.
LIMB_W, 64, limb width of the shared multiplier.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
valid  input  1  start request; operands sampled when valid && !busy
a  input  a_len  multiplicand
b  input  a_len  multiplier
busy  output  1  high while a multiplication is in progress
p  output  p_len  registered product a*b; held until the next finish
finish  output  1  one-cycle pulse, p valid in the same cycle

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, acc=0, p=0, finish=0, busy=0. Reset mid-operation aborts the operation with no finish pulse. The first valid after rst deasserts is accepted normally.
- FSM states: IDLE, MUL, DONE.
  - IDLE: on valid, latch a into ra and b into rb, clear acc, set k=0, go to MUL. busy=1 from the next cycle.
  - MUL: each cycle, with i=k/3 and j=k%3, compute acc += ra[i]*rb[j] << (64*(i+j)). k runs 0..8 in order (0,0),(0,1),(0,2),(1,0)..(2,2). After k=8, go to DONE.
  - DONE: p <= acc, finish=1 for exactly one cycle, busy=0, then go to IDLE.
- Latency: finish is asserted 11 cycles after the edge that sampled valid (1 capture + 9 MUL + 1 DONE). Throughput is one result per 11 cycles.
- The accumulator is p_len wide. No overflow is possible because a*b < 2^384. Partial-sum carry is kept internally, and no carry-out is exposed.
- valid while busy=1 is ignored and not queued. valid in the DONE cycle is also ignored, because state becomes IDLE only on the next edge. The upstream must wait for busy=0 and finish=0.
- a and b may change freely after capture without affecting the result.
- p is stable between finish pulses and is never partially updated.

Optional Feature:
GF_MUL_SQR_EN
- Defined: at capture, compare a==b. If equal, run a squaring schedule of 6 products: (0,0),(0,1),(0,2),(1,1),(1,2),(2,2). Off-diagonal products are added shifted left by one extra bit (doubled). finish then comes 8 cycles after capture. Results are bit-identical to the general path. The non-equal case is unchanged at 11 cycles.
- Not defined: no comparator. All operations take the 9-product schedule and 11 cycles.

Test Plan:
- rst, then a=1, b=1, valid for 1 cycle -> busy high for the next 10 cycles; finish pulse 11 cycles after capture with p=1.
- a=b=2^192-1 -> p = 2^384 - 2^193 + 1. Latency is 11 cycles, or 8 with GF_MUL_SQR_EN defined.
- Limb-placement checks:
  - a=2^64, b=2^128 -> p=2^192.
  - a=0xFFFFFFFFFFFFFFFF, b=2^128+1 -> p = 0xFFFFFFFFFFFFFFFF*2^128 + 0xFFFFFFFFFFFFFFFF.
- Start a=3, b=5, then hold valid high with a=7, b=7 for 4 mid-operation cycles -> only one finish, p=15. Also re-assert valid in the DONE cycle -> ignored; it is accepted the cycle after.
- Start a*b, then assert rst at MUL k=4 -> no finish pulse, p=0, busy=0. A new a=2, b=3 then gives p=6 after 11 cycles.
- Back-to-back: valid asserted again one cycle after finish -> accepted. Both products are correct, and the first p stays held until the second finish.
